// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants and helpers for the pipeline latch chain.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          DEFAULT_W = 16;
    localparam logic [15:0] NOP_WORD  = 16'h0800;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 16'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Purpose  : One pipeline latch (valid, payload, error) with load/hold/bubble/flush selects.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   NOP = 16'h0800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         hold,
    input  logic         bubble,
    input  logic         flush,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    input  logic         d_err,
    output logic         q_valid,
    output logic [W-1:0] q_data,
    output logic         q_err
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;
    logic         err_d,   err_q;

    // Flush outranks hold so a taken branch always kills the younger stages.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (flush || (!hold && bubble)) begin
            valid_d = 1'b0;
            data_d  = NOP;
            err_d   = 1'b0;
        end else if (hold) begin
            valid_d = valid_q;
            data_d  = data_q;
            err_d   = err_q;
        end else if (load) begin
            valid_d = d_valid;
            data_d  = d_data;
            err_d   = d_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;
    assign q_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline latch chain with stall propagation, bubbles, flush and counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int           STAGES       = 4,
    parameter int           W            = DEFAULT_W,
    parameter logic [W-1:0] NOP          = W'(NOP_WORD),
    parameter int           FLUSH_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    input  logic                  in_err,
    input  logic [STAGES-1:0]     hold,
    input  logic                  flush,
    output logic                  in_ready,
    output logic [STAGES-1:0]     stage_valid,
    output logic [STAGES*W-1:0]   stage_data,
    output logic [STAGES-1:0]     stage_err,
    output logic                  retire,
    output logic                  err,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           bubble_count
);

    logic [STAGES-1:0] w_frozen;
    logic [STAGES-1:0] w_bubble;
    logic [STAGES-1:0] w_flush;
    logic              w_stall_inc;
    logic              w_bubble_inc;

    logic        err_d,          err_q;
    logic [15:0] stall_cycles_d, stall_cycles_q;
    logic [15:0] bubble_count_d, bubble_count_q;

    // A hold freezes its own stage and everything younger than it.
    assign w_frozen[STAGES-1] = hold[STAGES-1];
    for (genvar i = 0; i < STAGES - 1; i++) begin : g_frozen
        assign w_frozen[i] = hold[i] | w_frozen[i+1];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic         w_in_valid;
        logic [W-1:0] w_in_data;
        logic         w_in_err;
        logic         w_prev_frozen;

        if (i == 0) begin : g_head
            assign w_in_valid    = in_valid;
            assign w_in_data     = in_valid ? in_data : NOP;
            assign w_in_err      = in_valid & in_err;
            assign w_prev_frozen = 1'b0;
        end else begin : g_body
            assign w_in_valid    = stage_valid[i-1];
            assign w_in_data     = stage_data[(i-1)*W +: W];
            assign w_in_err      = stage_err[i-1];
            assign w_prev_frozen = w_frozen[i-1];
        end

        assign w_flush[i]  = flush && (i < FLUSH_STAGES);
        assign w_bubble[i] = w_prev_frozen & ~w_frozen[i];

        pipe_stage #(
            .W   (W),
            .NOP (NOP)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (~w_frozen[i] & ~w_prev_frozen),
            .hold    (w_frozen[i]),
            .bubble  (w_bubble[i]),
            .flush   (w_flush[i]),
            .d_valid (w_in_valid),
            .d_data  (w_in_data),
            .d_err   (w_in_err),
            .q_valid (stage_valid[i]),
            .q_data  (stage_data[i*W +: W]),
            .q_err   (stage_err[i])
        );
    end

    assign in_ready     = ~w_frozen[IFID];
    assign retire       = stage_valid[STAGES-1] & ~hold[STAGES-1];
    assign w_stall_inc  = w_frozen[IFID] & ~flush;
    assign w_bubble_inc = |(w_bubble & ~w_flush);

    always_comb begin
        err_d          = err_q | (retire & stage_err[STAGES-1]);
        stall_cycles_d = sat_inc(stall_cycles_q, w_stall_inc);
        bubble_count_d = sat_inc(bubble_count_q, w_bubble_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q          <= 1'b0;
            stall_cycles_q <= 16'd0;
            bubble_count_q <= 16'd0;
        end else begin
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign err          = err_q;
    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;

endmodule
`default_nettype wire
